alu_issue_stage: RTL and testbench

Registered command-issue and result-capture stage wrapped around the combinational `n`-bit ALU. It accepts compact ALU commands through a valid/ready handshake and buffers them in a 4-deep FIFO. It decodes the head command into the ALU's `S`/`M`/`Cin` controls and registers `DO` plus the `C`/`V`/`N`/`Z` flags into a valid/ready result port. This turns the purely combinational ALU into a pipelined, back-pressurable datapath stage.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_issue_stage_if.sv | 52 +++++
 rtl/alu_cmd_fifo.sv | 58 +++++
 rtl/alu_issue_stage.sv | 94 +++++++++
 tb/tb_alu_issue_stage.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU command definitions: opcodes, control encodings, flag positions
// and the opcode decoder applied at the head of the command FIFO.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd16;
  localparam logic [4:0] OP_SUB = 5'd17;

  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // Flags reported for an illegal opcode: only Z set, matching the forced zero data.
  localparam logic [3:0] ILLEGAL_FLAGS = 4'b0001;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
    logic       cin;
    logic       illegal;
  } alu_ctrl_t;

  // Opcodes 0-15 select a logic function directly, 16/17 are ADD/SUB, the rest are illegal.
  function automatic alu_ctrl_t decode_op(input logic [4:0] op);
    alu_ctrl_t c;
    c = '{s: 4'b0000, m: 1'b0, cin: 1'b1, illegal: 1'b0};
    if (!op[4]) begin
      c.s = op[3:0];
    end else if (op == OP_ADD) begin
      c.s   = S_ADD;
      c.m   = 1'b1;
      c.cin = 1'b0;
    end else if (op == OP_SUB) begin
      c.s   = S_SUB;
      c.m   = 1'b1;
      c.cin = 1'b1;
    end else begin
      c.illegal = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Command, ALU and result signals of the issue stage, bundled for port use.
interface alu_issue_stage_if #(
  parameter int n     = 32,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_op;
  logic [n-1:0]  in_a;
  logic [n-1:0]  in_b;

  logic [n-1:0]  alu_opA;
  logic [n-1:0]  alu_opB;
  logic [3:0]    alu_S;
  logic          alu_M;
  logic          alu_Cin;
  logic [n-1:0]  alu_DO;
  logic          alu_C;
  logic          alu_V;
  logic          alu_N;
  logic          alu_Z;

  logic          out_valid;
  logic          out_ready;
  logic [n-1:0]  out_data;
  logic [3:0]    out_flags;
  logic          out_err;
  logic [LW-1:0] level;

  // The issue stage itself.
  modport slave (
    input  in_valid, in_op, in_a, in_b,
    input  alu_DO, alu_C, alu_V, alu_N, alu_Z,
    input  out_ready,
    output in_ready,
    output alu_opA, alu_opB, alu_S, alu_M, alu_Cin,
    output out_valid, out_data, out_flags, out_err, level
  );

  // The surroundings: command producer, ALU and result consumer.
  modport master (
    output in_valid, in_op, in_a, in_b,
    output alu_DO, alu_C, alu_V, alu_N, alu_Z,
    output out_ready,
    input  in_ready,
    input  alu_opA, alu_opB, alu_S, alu_M, alu_Cin,
    input  out_valid, out_data, out_flags, out_err, level
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with asynchronous reset and an explicit occupancy counter.
module alu_cmd_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             push;
  logic             pop;

  // Full blocks pushes even if a pop happens in the same cycle.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_data = mem[rd_ptr];

  // Write storage on accepted push.
  // NOTE: storage has no reset; entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage around a combinational ALU: buffers raw commands, decodes the
// FIFO head into ALU controls and registers the ALU response into a result port.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int n     = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_stage_if.slave  bus
);
  localparam int CW = 5 + 2 * n;

  logic [CW-1:0] head;
  logic [4:0]    head_op;
  logic [n-1:0]  head_a;
  logic [n-1:0]  head_b;
  logic          full;
  logic          empty;
  logic          capture;
  alu_ctrl_t     ctrl;
  logic [3:0]    alu_flags;

  logic          out_valid_q;
  logic [n-1:0]  out_data_q;
  logic [3:0]    out_flags_q;
  logic          out_err_q;

  alu_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.in_valid),
    .wr_data ({bus.in_op, bus.in_a, bus.in_b}),
    .rd_en   (capture),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (bus.level)
  );

  assign {head_op, head_a, head_b} = head;
  assign ctrl        = decode_op(head_op);
  assign capture     = !empty && (!out_valid_q || bus.out_ready);

  assign bus.in_ready  = !full;
  assign bus.alu_opA   = head_a;
  assign bus.alu_opB   = head_b;
  assign bus.alu_S     = ctrl.s;
  assign bus.alu_M     = ctrl.m;
  assign bus.alu_Cin   = ctrl.cin;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;
  assign bus.out_err   = out_err_q;

  // Pack the ALU flags into {C,V,N,Z} order.
  // NOTE: default every always_comb output first so no path infers a latch.
  always_comb begin
    alu_flags         = '0;
    alu_flags[FLAG_C] = bus.alu_C;
    alu_flags[FLAG_V] = bus.alu_V;
    alu_flags[FLAG_N] = bus.alu_N;
    alu_flags[FLAG_Z] = bus.alu_Z;
  end

  // Result register: load on capture, clear valid when consumed, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
      out_err_q   <= 1'b0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      if (ctrl.illegal) begin
        out_data_q  <= '0;
        out_flags_q <= ILLEGAL_FLAGS;
        out_err_q   <= 1'b1;
      end else begin
        out_data_q  <= bus.alu_DO;
        out_flags_q <= alu_flags;
        out_err_q   <= 1'b0;
      end
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU in the loop.
module tb_alu_issue_stage;

  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  alu_issue_stage_if #(.n(N), .DEPTH(DEPTH)) bus ();

  alu_issue_stage #(.n(N), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: M=1 arithmetic (SUB encoding inverts B), M=0 bitwise
  // function where S is a truth table indexed by {a_i, b_i}.
  logic [N-1:0] bx;
  logic [N:0]   sum;
  logic [N-1:0] res;
  logic         c_f;
  logic         v_f;
  always_comb begin
    bx  = (bus.alu_S == 4'b0110) ? ~bus.alu_opB : bus.alu_opB;
    sum = {1'b0, bus.alu_opA} + {1'b0, bx} + {{N{1'b0}}, bus.alu_Cin};
    res = '0;
    c_f = 1'b0;
    v_f = 1'b0;
    if (bus.alu_M) begin
      res = sum[N-1:0];
      c_f = sum[N];
      v_f = (bus.alu_opA[N-1] == bx[N-1]) && (sum[N-1] != bus.alu_opA[N-1]);
    end else begin
      for (int i = 0; i < N; i++) res[i] = bus.alu_S[{bus.alu_opA[i], bus.alu_opB[i]}];
    end
    bus.alu_DO = res;
    bus.alu_C  = c_f;
    bus.alu_V  = v_f;
    bus.alu_N  = res[N-1];
    bus.alu_Z  = (res == '0);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  ctrl;   // {S, M, Cin}
    logic [31:0] data;
    logic [3:0]  flags;  // {C, V, N, Z}
    logic        err;
  } vec_t;

  vec_t vecs [13];

  // Push one command into an empty stage and check decode, latency and result.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = v.op;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check({v.name, "_ctrl"}, 64'({bus.alu_S, bus.alu_M, bus.alu_Cin}), 64'(v.ctrl));
    check({v.name, "_early"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    check({v.name, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({v.name, "_data"},  64'(bus.out_data),  64'(v.data));
    check({v.name, "_flags"}, 64'(bus.out_flags), 64'(v.flags));
    check({v.name, "_err"},   64'(bus.out_err),   64'(v.err));
  endtask

  // Let the stage empty out with the consumer ready, bounded by a cycle budget.
  task automatic drain(input string name);
    bit done = 1'b0;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (bus.level == '0 && !bus.out_valid) done = 1'b1;
    end
    check({name, "_drained"}, 64'(done), 64'd1);
  endtask

  task automatic push_add(input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = 5'd16;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;

    vecs[0]  = '{"add_wrap",  5'd16, 32'hFFFF_FFFF, 32'h0000_0001, 6'b1001_10, 32'h0000_0000, 4'b1001, 1'b0};
    vecs[1]  = '{"sub_neg",   5'd17, 32'h0000_0005, 32'h0000_0007, 6'b0110_11, 32'hFFFF_FFFE, 4'b0010, 1'b0};
    vecs[2]  = '{"and",       5'd8,  32'hF0F0_F0F0, 32'hFF00_FF00, 6'b1000_01, 32'hF000_F000, 4'b0010, 1'b0};
    vecs[3]  = '{"illegal25", 5'd25, 32'h0000_1234, 32'h0000_5678, 6'b0000_01, 32'h0000_0000, 4'b0001, 1'b1};
    vecs[4]  = '{"or",        5'd14, 32'h0000_FFFF, 32'h00FF_0000, 6'b1110_01, 32'h00FF_FFFF, 4'b0000, 1'b0};
    vecs[5]  = '{"xor_same",  5'd6,  32'h1234_5678, 32'h1234_5678, 6'b0110_01, 32'h0000_0000, 4'b0001, 1'b0};
    vecs[6]  = '{"zero",      5'd0,  32'hAAAA_5555, 32'h5555_AAAA, 6'b0000_01, 32'h0000_0000, 4'b0001, 1'b0};
    vecs[7]  = '{"ones",      5'd15, 32'h0000_0000, 32'h0000_0000, 6'b1111_01, 32'hFFFF_FFFF, 4'b0010, 1'b0};
    vecs[8]  = '{"pass_a",    5'd12, 32'h8000_0000, 32'h0000_0000, 6'b1100_01, 32'h8000_0000, 4'b0010, 1'b0};
    vecs[9]  = '{"add_ovf",   5'd16, 32'h7FFF_FFFF, 32'h0000_0001, 6'b1001_10, 32'h8000_0000, 4'b0110, 1'b0};
    vecs[10] = '{"sub_eq",    5'd17, 32'h0000_0009, 32'h0000_0009, 6'b0110_11, 32'h0000_0000, 4'b1001, 1'b0};
    vecs[11] = '{"illegal18", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'b0000_01, 32'h0000_0000, 4'b0001, 1'b1};
    vecs[12] = '{"illegal31", 5'd31, 32'h0000_0001, 32'h0000_0002, 6'b0000_01, 32'h0000_0000, 4'b0001, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_level",     64'(bus.level),     64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    check("rst_out_flags", 64'(bus.out_flags), 64'd0);
    check("rst_out_err",   64'(bus.out_err),   64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single-command vectors
    for (int i = 0; i < 13; i++) apply_vec(vecs[i]);
    drain("vectors");

    // Back-pressure: 6 offered, 5 accepted, then in-order drain
    @(negedge clk);
    bus.out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      push_add(32'(i), 32'd100);
      if (bus.in_ready) accepted++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_accepted", 64'(accepted),      64'd5);
    check("bp_level",    64'(bus.level),     64'd4);
    check("bp_in_ready", 64'(bus.in_ready),  64'd0);
    check("bp_hold",     64'(bus.out_data),  64'd100);
    check("bp_valid",    64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk); #1;
      check("bp_drain_valid", 64'(bus.out_valid), 64'd1);
      check("bp_drain_data",  64'(bus.out_data),  64'(100 + j));
      check("bp_drain_level", 64'(bus.level),     64'(4 - j));
    end
    @(posedge clk); #1;
    check("bp_done_valid", 64'(bus.out_valid), 64'd0);

    // Simultaneous push and pop at level 2
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      push_add(32'(200 + k), 32'd0);
    end
    @(negedge clk);
    check("pp_start_level", 64'(bus.level),    64'd2);
    check("pp_start_data",  64'(bus.out_data), 64'd200);
    bus.out_ready = 1'b1;
    for (int k = 3; k < 13; k++) begin
      if (k > 3) @(negedge clk);
      push_add(32'(200 + k), 32'd0);
      @(posedge clk); #1;
      check("pp_level", 64'(bus.level),    64'd2);
      check("pp_data",  64'(bus.out_data), 64'(200 + k - 2));
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("pp_tail0", 64'(bus.out_data), 64'd211);
    @(posedge clk); #1;
    check("pp_tail1", 64'(bus.out_data), 64'd212);
    drain("pp");

    // Asynchronous reset mid-stream
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      push_add(32'(300 + k), 32'd0);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("ar_pre_level", 64'(bus.level),     64'd3);
    check("ar_pre_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid",    64'(bus.out_valid), 64'd0);
    check("ar_level",    64'(bus.level),     64'd0);
    check("ar_in_ready", 64'(bus.in_ready),  64'd1);
    check("ar_data",     64'(bus.out_data),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("ar_no_stale", 64'(bus.out_valid), 64'd0);
    end
    apply_vec(vecs[1]);
    drain("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
